mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 clock  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-003 start  in  1  request from control unit; sampled only in IDLE.
REQ-004 op  in  1  0 = mult (signed), 1 = div (signed).
REQ-005 a  in  32  operand A (multiplicand / dividend), two's complement.
REQ-006 b  in  32  operand B (multiplier / divisor), two's complement.
REQ-007 hi  out  32  mult: product[63:32]; div: remainder.
REQ-008 lo  out  32  mult: product[31:0]; div: quotient.
REQ-009 busy  out  1  high in any state other than IDLE.
REQ-010 done  out  1  one-cycle pulse; hi/lo valid from this cycle on.
REQ-011 div_zero  out  1  one-cycle pulse with done when a div had b == 0.

Function
REQ-012 The FSM SHALL have exactly five states: IDLE, MULT, DIV, FIX, DONE.
REQ-013 IDLE: start=1, op=0 -> MULT; start=1, op=1, b!=0 -> DIV; start=1, op=1, b==0 -> DONE with div_zero; else stay.
REQ-014 a and b SHALL be captured on the accepting edge; later changes on a/b SHALL NOT affect the running operation.
REQ-015 start SHALL be ignored in every state except IDLE, with no queueing.
REQ-016 MULT SHALL perform radix-2 Booth, one step per cycle, with a 6-bit step counter; after the 32nd step -> DONE.
REQ-017 DIV SHALL perform restoring division on operand magnitudes, one quotient bit per cycle; after the 32nd step -> FIX.
REQ-018 FIX SHALL negate the quotient when sign(a) != sign(b), and negate the remainder when a < 0; then -> DONE.
REQ-019 0x80000000 / -1 SHALL give lo = 0x80000000, hi = 0, with no flag.
REQ-020 DONE SHALL assert done for exactly one cycle, then -> IDLE unconditionally.
REQ-021 hi/lo SHALL update only on the edge entering DONE, and otherwise hold, including during a following operation.
REQ-022 On divide-by-zero, hi/lo SHALL keep their previous values.
REQ-023 Latency, measured from the accepting edge E: mult done is high after edge E+32; div done is high after edge E+33; div-by-zero done is high after edge E+1.
REQ-024 The earliest new start SHALL be accepted on the edge after done; back-to-back operations SHALL have no extra bubble.

Reset
REQ-025 reset=1 SHALL, on the next edge, force IDLE and clear hi, lo, step counter and internal registers.
REQ-026 After that edge busy, done and div_zero SHALL be 0.
REQ-027 reset SHALL take priority over start in the same cycle.
REQ-028 reset mid-operation SHALL abort the operation with no done pulse.

Configuration
REQ-029 Macro MDU_DIV_EN defined: division supported as in REQ-013/017/018/019/022 and div_zero functional.
REQ-030 MDU_DIV_EN undefined: DIV and FIX states and divider datapath are not built.
REQ-031 MDU_DIV_EN undefined: start with op=1 is ignored (stays IDLE, no busy, no done), and div_zero is tied to 0.

Verification
REQ-032 mult a=7, b=0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done after edge E+32, busy high E+1..E+32.
REQ-033 mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000; then an immediate second start is accepted on the edge after done.
REQ-034 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, done after edge E+33; and div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 div a=5, b=0 after a prior result hi=1, lo=2 -> done and div_zero high after edge E+1, hi=1, lo=2 unchanged.
REQ-036 reset asserted 10 cycles into a mult -> busy=0, hi=lo=0, and no done; a start raised while busy is ignored and the result matches the first operands.
REQ-037 Build without MDU_DIV_EN, start with op=1 -> busy stays 0 for 40 cycles, no done; mult results identical to REQ-032.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential signed 32x32 multiply (radix-2 Booth) / divide (restoring) unit
// Divider is built only when MDU_DIV_EN is defined; busy/done/div_zero are registered from the FSM state.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state;
    logic [5:0]  step;
    logic [32:0] mcand;
    logic [32:0] acc;
    logic [31:0] mq;
    logic        mq_m1;

    logic [32:0] src_mcand;
    logic [32:0] src_acc;
    logic [31:0] src_q;
    logic        src_m1;
    logic [32:0] booth_sum;
    logic [32:0] acc_nxt;
    logic [31:0] mq_nxt;

    // The first step runs on the accepting edge, straight from the a/b inputs.
    always_comb begin
        if (state == IDLE) begin
            src_mcand = {a[31], a};
            src_acc   = '0;
            src_q     = b;
            src_m1    = 1'b0;
        end else begin
            src_mcand = mcand;
            src_acc   = acc;
            src_q     = mq;
            src_m1    = mq_m1;
        end
        booth_sum = src_acc;
        if (src_q[0] && !src_m1)
            booth_sum = src_acc - src_mcand;
        else if (!src_q[0] && src_m1)
            booth_sum = src_acc + src_mcand;
        acc_nxt = {booth_sum[32], booth_sum[32:1]};
        mq_nxt  = {booth_sum[0], src_q[31:1]};
    end

`ifdef MDU_DIV_EN
    logic [31:0] dvsr;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] src_dvsr;
    logic [31:0] src_rem;
    logic [31:0] src_quo;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [32:0] shifted;
    logic        neg_q;
    logic        neg_r;
    logic        zero_div;

    // Restoring step on magnitudes; the quotient register doubles as the dividend shifter.
    always_comb begin
        if (state == IDLE) begin
            src_dvsr = b[31] ? -b : b;
            src_rem  = '0;
            src_quo  = a[31] ? -a : a;
        end else begin
            src_dvsr = dvsr;
            src_rem  = rem;
            src_quo  = quo;
        end
        shifted = {src_rem, src_quo[31]};
        if (shifted >= {1'b0, src_dvsr}) begin
            rem_nxt = shifted[31:0] - src_dvsr;
            quo_nxt = {src_quo[30:0], 1'b1};
        end else begin
            rem_nxt = shifted[31:0];
            quo_nxt = {src_quo[30:0], 1'b0};
        end
    end
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            step     <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            mq       <= '0;
            mq_m1    <= 1'b0;
`ifdef MDU_DIV_EN
            div_zero <= 1'b0;
            zero_div <= 1'b0;
            dvsr     <= '0;
            rem      <= '0;
            quo      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            busy <= (state != IDLE);
            done <= (state == DONE);
`ifdef MDU_DIV_EN
            div_zero <= (state == DONE) && zero_div;
`endif
            case (state)
                IDLE: begin
                    if (start && !op) begin
                        state <= MULT;
                        step  <= 6'd1;
                        mcand <= src_mcand;
                        acc   <= acc_nxt;
                        mq    <= mq_nxt;
                        mq_m1 <= src_q[0];
                    end
`ifdef MDU_DIV_EN
                    else if (start && b == '0) begin
                        state    <= DONE;
                        zero_div <= 1'b1;
                    end else if (start) begin
                        state <= DIV;
                        step  <= 6'd1;
                        dvsr  <= src_dvsr;
                        rem   <= rem_nxt;
                        quo   <= quo_nxt;
                        neg_q <= a[31] ^ b[31];
                        neg_r <= a[31];
                    end
`endif
                end
                MULT: begin
                    acc   <= acc_nxt;
                    mq    <= mq_nxt;
                    mq_m1 <= src_q[0];
                    step  <= step + 6'd1;
                    if (step == 6'd31) begin
                        state <= DONE;
                        hi    <= acc_nxt[31:0];
                        lo    <= mq_nxt;
                    end
                end
`ifdef MDU_DIV_EN
                DIV: begin
                    rem  <= rem_nxt;
                    quo  <= quo_nxt;
                    step <= step + 6'd1;
                    if (step == 6'd31)
                        state <= FIX;
                end
                FIX: begin
                    state <= DONE;
                    lo    <= neg_q ? -quo : quo;
                    hi    <= neg_r ? -rem : rem;
                end
`endif
                DONE: begin
                    state <= IDLE;
`ifdef MDU_DIV_EN
                    zero_div <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
// Division scenarios run when MDU_DIV_EN is defined, otherwise the disabled-divider behaviour is checked.
module tb_mult_div_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mult_div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Returns just after the accepting edge; operands are then scrambled.
    task automatic start_op(input logic o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 32'hDEADBEEF;
        b     = 32'h0BADF00D;
    endtask

    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 40) begin
            tick();
            lat++;
            if (!busy) busy_ok = 1'b0;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd7;
        b     = 32'd3;
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_div_zero got=%b exp=0", div_zero); end
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset_hilo got=%h_%h exp=0", hi, lo); end
        start = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mult(input string name, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] eh, input logic [31:0] el);
        int   lat;
        logic bok;
        start_op(1'b0, x, y);
        wait_done(lat, bok);
        total++; if (lat !== 32) begin bad++; $display("FAIL %s latency got=%0d exp=32", name, lat); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL %s busy_during got=%b exp=1", name, bok); end
        total++; if (hi !== eh) begin bad++; $display("FAIL %s hi got=%h exp=%h", name, hi, eh); end
        total++; if (lo !== el) begin bad++; $display("FAIL %s lo got=%h exp=%h", name, lo, el); end
        tick();
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL %s after_done busy,done got=%b%b exp=00", name, busy, done); end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic bok;
        start_op(1'b0, 32'h80000000, 32'h80000000);
        wait_done(lat, bok);
        total++; if (lat !== 32) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=32", lat); end
        total++; if ({hi, lo} !== 64'h40000000_00000000) begin bad++; $display("FAIL b2b_first_result got=%h_%h exp=40000000_00000000", hi, lo); end
        start_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_pulse got=%b exp=0", done); end
        wait_done(lat, bok);
        total++; if (lat !== 32) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=32", lat); end
        total++; if ({hi, lo} !== 64'h00000000_00000001) begin bad++; $display("FAIL b2b_second_result got=%h_%h exp=00000000_00000001", hi, lo); end
        tick();
    endtask

    task automatic test_reset_abort();
        logic seen_done;
        start_op(1'b0, 32'd3, 32'd5);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL abort_hilo got=%h_%h exp=0", hi, lo); end
        seen_done = done;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
    endtask

    task automatic test_start_ignored();
        int   lat;
        logic bok;
        start_op(1'b0, 32'd3, 32'd5);
        repeat (5) tick();
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd9;
        b     = 32'd9;
        tick();
        start = 1'b0;
        wait_done(lat, bok);
        total++; if (lat + 6 !== 32) begin bad++; $display("FAIL ignore_latency got=%0d exp=32", lat + 6); end
        total++; if ({hi, lo} !== 64'd15) begin bad++; $display("FAIL ignore_result got=%h_%h exp=00000000_0000000f", hi, lo); end
        tick();
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div(input string name, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] eq, input logic [31:0] er);
        int   lat;
        logic bok;
        start_op(1'b1, x, y);
        wait_done(lat, bok);
        total++; if (lat !== 33) begin bad++; $display("FAIL %s latency got=%0d exp=33", name, lat); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL %s busy_during got=%b exp=1", name, bok); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL %s div_zero got=%b exp=0", name, div_zero); end
        total++; if (lo !== eq) begin bad++; $display("FAIL %s quotient got=%h exp=%h", name, lo, eq); end
        total++; if (hi !== er) begin bad++; $display("FAIL %s remainder got=%h exp=%h", name, hi, er); end
        tick();
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL %s after_done busy,done got=%b%b exp=00", name, busy, done); end
    endtask

    task automatic test_div_zero();
        int   lat;
        logic bok;
        test_div("div_5_2", 32'd5, 32'd2, 32'd2, 32'd1);
        start_op(1'b1, 32'd5, 32'd0);
        wait_done(lat, bok);
        total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency got=%0d exp=1", lat); end
        total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", div_zero); end
        total++; if ({hi, lo} !== {32'd1, 32'd2}) begin bad++; $display("FAIL dz_hold got=%h_%h exp=00000001_00000002", hi, lo); end
        tick();
        total++; if ({div_zero, done} !== 2'b00) begin bad++; $display("FAIL dz_pulse got=%b%b exp=00", div_zero, done); end
    endtask
`else
    task automatic test_div_disabled();
        logic seen_busy;
        logic seen_done;
        start_op(1'b1, 32'd5, 32'd2);
        seen_busy = busy;
        seen_done = done | div_zero;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy) seen_busy = 1'b1;
            if (done || div_zero) seen_done = 1'b1;
        end
        total++; if (seen_busy !== 1'b0) begin bad++; $display("FAIL nodiv_busy got=%b exp=0", seen_busy); end
        total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL nodiv_done got=%b exp=0", seen_done); end
        test_mult("nodiv_mult_7_m3", 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    endtask
`endif

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_mult("mult_7_m3", 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        test_mult("mult_shift", 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780);
        test_mult("mult_m1_m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        test_back_to_back();
        test_reset_abort();
        test_start_ignored();
`ifdef MDU_DIV_EN
        test_div("div_m7_2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        test_div("div_7_m2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001);
        test_div("div_100_7", 32'd100, 32'd7, 32'd14, 32'd2);
        test_div("div_min_m1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
        test_div_zero();
`else
        test_div_disabled();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
